// File: rtl/cska_pkg.sv
// Shared types for the cska8b operand sequencer.
// State encoding and byte width used across the slice.
package cska_pkg;

  localparam int BYTE_W         = 8;
  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    GUARD,
    SETTLE,
    HOLD
  } state_e;

endpackage

// File: rtl/cska8b_op_sequencer.sv
// Feeds A/B bytes into the cska8b controller latch safely and
// returns each byte result with a carry chained across a word.
module cska8b_op_sequencer
  import cska_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_DEFAULT,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [BYTE_W-1:0] op_data,
  input  logic              op_first,
  input  logic              op_sub,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BYTE_W-1:0] res_data,
  output logic              res_cout,
  output logic [BYTE_W-1:0] add_in,
  output logic              add_store_a,
  output logic              add_cin,
  input  logic [BYTE_W-1:0] add_out,
  input  logic              add_cout
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] a_q, a_d;
  logic [BYTE_W-1:0] b_q, b_d;
  logic              sub_q, sub_d;
  logic              first_q, first_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rv_q, rv_d;
  logic [BYTE_W-1:0] rd_q, rd_d;
  logic              rc_q, rc_d;
  logic              cin_eff;

  assign cin_eff   = first_q ? sub_q : carry_q;
  assign res_valid = rv_q;
  assign res_data  = rd_q;
  assign res_cout  = rc_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    first_d     = first_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    rv_d        = rv_q;
    rd_d        = rd_q;
    rc_d        = rc_q;
    op_ready    = 1'b0;
    add_in      = '0;
    add_store_a = 1'b0;
    add_cin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        op_ready = rst_n;
        if (op_valid) begin
          a_d     = op_data;
          sub_d   = op_sub;
          first_d = op_first;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        add_in      = a_q;
        add_store_a = 1'b1;
        op_ready    = rst_n;
        if (op_valid) begin
          b_d     = sub_q ? ~op_data : op_data;
          state_d = GUARD;
        end
      end
      // latch closes on A before the bus switches to B
      GUARD: begin
        add_in  = a_q;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        add_in  = b_q;
        add_cin = cin_eff;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          rd_d    = add_out;
          rc_d    = add_cout;
          carry_d = add_cout;
          rv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        add_in  = b_q;
        add_cin = cin_eff;
        if (res_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      first_q <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      first_q <= first_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rc_q    <= rc_d;
    end
  end

endmodule

// File: tb/tb_cska8b_op_sequencer.sv
// Directed bench for cska8b_op_sequencer with a behavioural
// controller: level latch on store_A feeding an 8-bit adder.
module tb_cska8b_op_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [7:0] op_data = 8'h00;
  logic       op_first = 1'b0;
  logic       op_sub = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_cout;
  logic [7:0] add_in;
  logic       add_store_a;
  logic       add_cin;
  logic [7:0] add_out;
  logic       add_cout;

  logic [7:0] a_lat;
  logic [8:0] sum9;
  logic [7:0] tb_a = 8'h00;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  cska8b_op_sequencer #(
    .SETTLE_CYCLES(S),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_data(op_data),
    .op_first(op_first),
    .op_sub(op_sub),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_cout(res_cout),
    .add_in(add_in),
    .add_store_a(add_store_a),
    .add_cin(add_cin),
    .add_out(add_out),
    .add_cout(add_cout)
  );

  always @(negedge clk) if (add_store_a) a_lat <= add_in;
  assign sum9 = {1'b0, a_lat} + {1'b0, add_in} + {8'b0, add_cin};
  assign add_out  = sum9[7:0];
  assign add_cout = sum9[8];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // latch may only be open while the bus carries the A byte
  always @(negedge clk) begin
    if (rst_n && add_store_a)
      check("latch_safe", 32'(add_in), 32'(tb_a));
  end

  task automatic push(input logic [7:0] d, input logic f,
                      input logic s);
    int n = 0;
    op_valid = 1'b1;
    op_data  = d;
    op_first = f;
    op_sub   = s;
    while (!op_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic f, input logic s,
                        input logic [7:0] ed, input logic ec,
                        input logic rel);
    int n = 0;
    tb_a = a;
    push(a, f, s);
    push(b, ~f, ~s);
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(S + 1));
    check({tag, "_data"}, 32'(res_data), 32'(ed));
    check({tag, "_cout"}, 32'(res_cout), 32'(ec));
    check({tag, "_alat"}, 32'(a_lat), 32'(a));
    if (rel) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, "_rv0"}, 32'(res_valid), 32'd0);
      check({tag, "_idle"}, 32'(op_ready), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] rs;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_cout", 32'(res_cout), 32'd0);
    check("rst_add_in", 32'(add_in), 32'd0);
    check("rst_store", 32'(add_store_a), 32'd0);
    check("rst_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 32'(op_ready), 32'd1);

    run_op("add", 8'h3C, 8'h15, 1'b1, 1'b0, 8'h51, 1'b0, 1'b1);
    run_op("ch0", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op("ch1", 8'h01, 8'h00, 1'b0, 1'b0, 8'h02, 1'b0, 1'b1);
    run_op("sub0", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b1);
    run_op("sub1", 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1);

    run_op("bp", 8'h80, 8'h81, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    op_valid = 1'b1;
    op_data  = 8'h77;
    op_first = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ready", 32'(op_ready), 32'd0);
      check("bp_data", 32'(res_data), 32'h01);
      check("bp_valid", 32'(res_valid), 32'd1);
    end
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_rv0", 32'(res_valid), 32'd0);
    check("bp_idle", 32'(op_ready), 32'd1);
    run_op("bp_next", 8'h01, 8'h01, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1);

    run_op("pre_rst", 8'hA0, 8'h70, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1);
    tb_a = 8'h12;
    push(8'h12, 1'b0, 1'b0);
    push(8'h34, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_op_ready", 32'(op_ready), 32'd0);
    check("mid_res_valid", 32'(res_valid), 32'd0);
    check("mid_res_data", 32'(res_data), 32'd0);
    check("mid_res_cout", 32'(res_cout), 32'd0);
    check("mid_add_in", 32'(add_in), 32'd0);
    check("mid_store", 32'(add_store_a), 32'd0);
    check("mid_cin", 32'(add_cin), 32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(op_ready), 32'd1);
    run_op("post_rst", 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = {1'b0, ra} + {1'b0, rb};
      run_op("rnd_add", ra, rb, 1'b1, 1'b0, rs[7:0], rs[8], 1'b1);
      rs = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
      run_op("rnd_sub", ra, rb, 1'b1, 1'b1, rs[7:0], rs[8], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
